dm_arbiter: RTL

- Arbitrates the single-port data memory (data_mem) between two requesters: the CPU load/store path (alu_out address, rf_rdata2 write data) and a DMA/debug port.
- Sequences every access through a small FSM: arbitrate, drive memory for one cycle, capture read data, acknowledge.
- Applies round-robin fairness, bounds DMA bursts so the CPU cannot starve, and range/alignment-checks addresses before they reach memory.

---
 rtl/dm_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - CPU/DMA arbiter for the single-port data memory
// Optional macro DM_ARB_STATS_EN adds per-owner ack counters with stat_clr.
module dm_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int MAX_DMA_RUN = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_err,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic          dma_err,
  output logic          mem_cs,
  output logic          mem_r,
  output logic          mem_w,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef DM_ARB_STATS_EN
  ,
  input  logic          stat_clr,
  output logic [15:0]   cpu_cnt,
  output logic [15:0]   dma_cnt
`endif
);

  localparam int RW = $clog2(MAX_DMA_RUN + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(MAX_DMA_RUN);
  localparam logic [AW-1:0] DEPTH_LIM = AW'(DEPTH_WORDS);
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;

  state_t         state, state_nxt;
  logic           owner, last_owner, pick, take;
  logic [RW-1:0]  dma_run;
  logic           lat_we, lat_err;
  logic [AW-1:0]  lat_addr;
  logic [DW-1:0]  lat_wdata;
  logic           sel_we, sel_err, granted;
  logic [AW-1:0]  sel_addr;
  logic [DW-1:0]  sel_wdata;

  function automatic logic addr_bad(input logic [AW-1:0] a);
    return (a[1:0] != 2'b00) || ({2'b00, a[AW-1:2]} >= DEPTH_LIM);
  endfunction

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    pick      = OWN_CPU;
    case (state)
      IDLE: begin
        if (cpu_req || dma_req) begin
          take      = 1'b1;
          state_nxt = GRANT;
          // Tie: alternate owners, but a saturated DMA run hands the slot to the CPU.
          if (cpu_req && dma_req)
            pick = (dma_run == RUN_MAX) ? OWN_CPU : ~last_owner;
          else
            pick = dma_req ? OWN_DMA : OWN_CPU;
        end
      end
      GRANT:   state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign sel_we    = (pick == OWN_DMA) ? dma_we    : cpu_we;
  assign sel_addr  = (pick == OWN_DMA) ? dma_addr  : cpu_addr;
  assign sel_wdata = (pick == OWN_DMA) ? dma_wdata : cpu_wdata;
  assign sel_err   = addr_bad(sel_addr);

  assign granted   = (state == GRANT) && !lat_err;
  assign mem_cs    = granted;
  assign mem_r     = granted && !lat_we;
  assign mem_w     = granted && lat_we;
  assign mem_addr  = granted ? lat_addr  : '0;
  assign mem_wdata = granted ? lat_wdata : '0;

  assign cpu_ack   = (state == ACK) && (owner == OWN_CPU);
  assign dma_ack   = (state == ACK) && (owner == OWN_DMA);
  assign cpu_err   = cpu_ack && lat_err;
  assign dma_err   = dma_ack && lat_err;
  assign cpu_stall = cpu_req && !cpu_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= OWN_CPU;
      last_owner <= OWN_DMA;
      dma_run    <= '0;
      lat_we     <= 1'b0;
      lat_err    <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        owner     <= pick;
        lat_we    <= sel_we;
        lat_addr  <= sel_addr;
        lat_wdata <= sel_wdata;
        lat_err   <= sel_err;
      end
      if (state == GRANT) begin
        if (lat_err) begin
          if (owner == OWN_DMA) dma_rdata <= '0;
          else                  cpu_rdata <= '0;
        end else if (!lat_we) begin
          if (owner == OWN_DMA) dma_rdata <= mem_rdata;
          else                  cpu_rdata <= mem_rdata;
        end
      end
      if (state == ACK) begin
        last_owner <= owner;
        if (owner == OWN_DMA)
          dma_run <= (dma_run == RUN_MAX) ? RUN_MAX : dma_run + RW'(1);
        else
          dma_run <= '0;
      end
    end
  end

`ifdef DM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_cnt <= '0;
      dma_cnt <= '0;
    end else if (stat_clr) begin
      cpu_cnt <= '0;
      dma_cnt <= '0;
    end else begin
      if (cpu_ack && cpu_cnt != 16'hFFFF) cpu_cnt <= cpu_cnt + 16'd1;
      if (dma_ack && dma_cnt != 16'hFFFF) dma_cnt <= dma_cnt + 16'd1;
    end
  end
`endif

endmodule
